// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// In-order branch resolution unit for the execute stage. Decoded conditional
// branches enter a circular FIFO from dispatch. Any source operands that are
// not yet available are captured from the common data bus (CDB). The oldest
// entry is evaluated once both of its operands are present. Its outcome is
// then broadcast on this unit's CDB port as {address = branch PC,
// value[0] = taken}. Outcomes leave strictly in dispatch order, because the
// branch predictor consumes them as a FIFO.
//
// Parameters
//   DEPTH_W     log2 of the number of FIFO entries
//   TAG_W       width of producer (ROB) tags
//
// Ports
//   clk_in      clock
//   rst_in      synchronous, active-high reset
//   rdy_in      global ready; low freezes all state and holds the outputs
//   flush_in    misprediction flush; empties the unit (effective when rdy_in)
//   in_valid    dispatch request
//   in_ready    dispatch can be accepted (!full && rdy_in)
//   in_op       branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   in_pc       branch PC
//   in_rsX_val  operand value, meaningful when in_rsX_rdy
//   in_rsX_tag  operand producer tag, meaningful when !in_rsX_rdy
//   in_rsX_rdy  operand already available at dispatch
//   cdb_valid   CDB broadcast valid
//   cdb_tag     CDB broadcasting producer tag
//   cdb_data    CDB broadcast value
//   br_req      request for a CDB slot (registered)
//   br_grant    CDB arbiter grant for this cycle
//   br_addr     resolved branch PC (registered)
//   br_val      {31'b0, taken} (registered)
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int DEPTH_W = 3,
    parameter int TAG_W   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    input  logic [TAG_W-1:0] in_rs1_tag,
    input  logic [TAG_W-1:0] in_rs2_tag,
    input  logic             in_rs1_rdy,
    input  logic             in_rs2_rdy,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             br_req,
    input  logic             br_grant,
    output logic [31:0]      br_addr,
    output logic [31:0]      br_val
);

    localparam int DEPTH = 1 << DEPTH_W;

    localparam logic [DEPTH_W-1:0] PTR_ZERO = {DEPTH_W{1'b0}};
    localparam logic [DEPTH_W-1:0] PTR_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_W:0]   CNT_ZERO = {(DEPTH_W+1){1'b0}};
    localparam logic [DEPTH_W:0]   CNT_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
    localparam logic [DEPTH_W:0]   CNT_FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [TAG_W-1:0]   TAG_ZERO = {TAG_W{1'b0}};

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } state_t;

    // Branch condition evaluation; undefined funct3 codes resolve not-taken.
    function automatic logic eval_taken(input logic [2:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic t;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) <  $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            OP_BLTU: t = (a <  b);
            OP_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Entry storage
    logic             valid_r [DEPTH];
    logic [2:0]       op_r    [DEPTH];
    logic [31:0]      pc_r    [DEPTH];
    logic [31:0]      v1_r    [DEPTH];
    logic [TAG_W-1:0] t1_r    [DEPTH];
    logic             r1_r    [DEPTH];
    logic [31:0]      v2_r    [DEPTH];
    logic [TAG_W-1:0] t2_r    [DEPTH];
    logic             r2_r    [DEPTH];

    logic [DEPTH_W-1:0] front_r;
    logic [DEPTH_W-1:0] rear_r;
    logic [DEPTH_W:0]   count_r;

    state_t      state_r;
    state_t      state_nx_s;
    logic        br_req_r;
    logic        br_req_nx_s;
    logic [31:0] br_addr_r;
    logic [31:0] br_addr_nx_s;
    logic [31:0] br_val_r;
    logic [31:0] br_val_nx_s;

    logic        full_s;
    logic        push_s;
    logic        pop_s;
    logic        head_ready_s;
    logic        head_taken_s;
    logic        capture_s;
    logic        in_r1_s;
    logic        in_r2_s;
    logic [31:0] in_v1_s;
    logic [31:0] in_v2_s;

    assign full_s   = (count_r == CNT_FULL);
    assign in_ready = !full_s && rdy_in;

    // in_ready already folds in rdy_in, so a push can never happen while paused.
    assign push_s = in_valid && in_ready && !flush_in;
    assign pop_s  = rdy_in && !flush_in && (state_r == ST_BCAST) && br_grant;

    // Only registered ready bits are used here. A CDB wakeup therefore
    // reaches the head check one cycle after it is written.
    assign head_ready_s = (count_r != CNT_ZERO) && r1_r[front_r] && r2_r[front_r];
    assign head_taken_s = eval_taken(op_r[front_r], v1_r[front_r], v2_r[front_r]);
    assign capture_s    = rdy_in && !flush_in && (state_r == ST_IDLE) && head_ready_s;

    // The CDB bypass lets an operand that is produced in the dispatch cycle
    // enter the FIFO already marked ready.
    assign in_r1_s = in_rs1_rdy || (cdb_valid && (cdb_tag == in_rs1_tag));
    assign in_r2_s = in_rs2_rdy || (cdb_valid && (cdb_tag == in_rs2_tag));
    assign in_v1_s = in_rs1_rdy ? in_rs1_val : cdb_data;
    assign in_v2_s = in_rs2_rdy ? in_rs2_val : cdb_data;

    // Entry storage: push write, CDB wakeup, pop invalidation and flush.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                op_r[i]    <= 3'b000;
                pc_r[i]    <= 32'd0;
                v1_r[i]    <= 32'd0;
                t1_r[i]    <= TAG_ZERO;
                r1_r[i]    <= 1'b0;
                v2_r[i]    <= 32'd0;
                t2_r[i]    <= TAG_ZERO;
                r2_r[i]    <= 1'b0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_r[i] <= 1'b0;
                    r1_r[i]    <= 1'b0;
                    r2_r[i]    <= 1'b0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_valid && valid_r[i] && !r1_r[i] && (t1_r[i] == cdb_tag)) begin
                        v1_r[i] <= cdb_data;
                        r1_r[i] <= 1'b1;
                    end
                    if (cdb_valid && valid_r[i] && !r2_r[i] && (t2_r[i] == cdb_tag)) begin
                        v2_r[i] <= cdb_data;
                        r2_r[i] <= 1'b1;
                    end
                end
                if (pop_s) begin
                    valid_r[front_r] <= 1'b0;
                end
                // The rear slot is never valid while a push is possible, so
                // this write cannot collide with a wakeup or pop above.
                if (push_s) begin
                    valid_r[rear_r] <= 1'b1;
                    op_r[rear_r]    <= in_op;
                    pc_r[rear_r]    <= in_pc;
                    v1_r[rear_r]    <= in_v1_s;
                    t1_r[rear_r]    <= in_rs1_tag;
                    r1_r[rear_r]    <= in_r1_s;
                    v2_r[rear_r]    <= in_v2_s;
                    t2_r[rear_r]    <= in_rs2_tag;
                    r2_r[rear_r]    <= in_r2_s;
                end
            end
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            front_r <= PTR_ZERO;
            rear_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else if (rdy_in) begin
            if (flush_in) begin
                front_r <= PTR_ZERO;
                rear_r  <= PTR_ZERO;
                count_r <= CNT_ZERO;
            end else begin
                if (push_s) begin
                    rear_r <= rear_r + PTR_ONE;
                end
                if (pop_s) begin
                    front_r <= front_r + PTR_ONE;
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_ONE;
                    2'b01:   count_r <= count_r - CNT_ONE;
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Head FSM state register together with the registered bus outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r   <= ST_IDLE;
            br_req_r  <= 1'b0;
            br_addr_r <= 32'd0;
            br_val_r  <= 32'd0;
        end else begin
            state_r   <= state_nx_s;
            br_req_r  <= br_req_nx_s;
            br_addr_r <= br_addr_nx_s;
            br_val_r  <= br_val_nx_s;
        end
    end

    // Head FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        if (!rdy_in) begin
            state_nx_s = state_r;
        end else if (flush_in) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (head_ready_s) begin
                        state_nx_s = ST_BCAST;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_BCAST: begin
                    if (br_grant) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_BCAST;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Head FSM output logic. The outcome is captured once on leaving IDLE and
    // is then held stable for the whole request.
    always_comb begin
        br_addr_nx_s = br_addr_r;
        br_val_nx_s  = br_val_r;
        if (capture_s) begin
            br_addr_nx_s = pc_r[front_r];
            br_val_nx_s  = {31'd0, head_taken_s};
        end else begin
            br_addr_nx_s = br_addr_r;
            br_val_nx_s  = br_val_r;
        end
        br_req_nx_s = (state_nx_s == ST_BCAST);
    end

    assign br_req  = br_req_r;
    assign br_addr = br_addr_r;
    assign br_val  = br_val_r;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

    localparam int DEPTH_W = 3;
    localparam int TAG_W   = 4;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_UND  = 3'b010;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             flush_in;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_pc;
    logic [31:0]      in_rs1_val;
    logic [31:0]      in_rs2_val;
    logic [TAG_W-1:0] in_rs1_tag;
    logic [TAG_W-1:0] in_rs2_tag;
    logic             in_rs1_rdy;
    logic             in_rs2_rdy;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             br_req;
    logic             br_grant;
    logic [31:0]      br_addr;
    logic [31:0]      br_val;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Signedness table: every entry uses rs1 = 0xFFFFFFFF and rs2 = 1.
    logic [2:0]  sg_op  [6] = '{OP_BLT, OP_BLTU, OP_BGEU, OP_BGE, OP_BNE, OP_UND};
    logic [31:0] sg_exp [6] = '{32'd1,  32'd0,   32'd1,   32'd0,  32'd1,  32'd0};

    branch_resolver #(.DEPTH_W(DEPTH_W), .TAG_W(TAG_W)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_pc      (in_pc),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .in_rs1_tag (in_rs1_tag),
        .in_rs2_tag (in_rs2_tag),
        .in_rs1_rdy (in_rs1_rdy),
        .in_rs2_rdy (in_rs2_rdy),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .br_req     (br_req),
        .br_grant   (br_grant),
        .br_addr    (br_addr),
        .br_val     (br_val)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_entry(input logic [2:0] op, input logic [31:0] pc,
                             input logic [31:0] v1, input logic [TAG_W-1:0] t1, input logic r1,
                             input logic [31:0] v2, input logic [TAG_W-1:0] t2, input logic r2);
        in_op      = op;
        in_pc      = pc;
        in_rs1_val = v1;
        in_rs1_tag = t1;
        in_rs1_rdy = r1;
        in_rs2_val = v2;
        in_rs2_tag = t2;
        in_rs2_rdy = r2;
    endtask

    task automatic push(input logic [2:0] op, input logic [31:0] pc,
                        input logic [31:0] v1, input logic [TAG_W-1:0] t1, input logic r1,
                        input logic [31:0] v2, input logic [TAG_W-1:0] t2, input logic r2);
        set_entry(op, pc, v1, t1, r1, v2, t2, r2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, check its payload, then let the grant pop it.
    task automatic expect_bcast(input string tag, input logic [31:0] pc, input logic [31:0] val);
        int n = 0;
        while (!br_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(br_req), 32'd1);
        chk({tag, "_addr"}, br_addr, pc);
        chk({tag, "_val"}, br_val, val);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        int n;
        int popped;
        int next_push;

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        in_valid = 1'b0;
        br_grant = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag  = 4'd0;
        cdb_data = 32'd0;
        set_entry(OP_BEQ, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
        repeat (3) tick();
        rst_in = 1'b0;

        // Reset state
        chk("rst_req", 32'(br_req), 32'd0);
        chk("rst_addr", br_addr, 32'd0);
        chk("rst_val", br_val, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic BEQ with grant tied high: request appears two cycles after the push
        br_grant = 1'b1;
        push(OP_BEQ, 32'h100, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0, 1'b1);
        chk("beq_req_early", 32'(br_req), 32'd0);
        tick();
        chk("beq_req", 32'(br_req), 32'd1);
        chk("beq_addr", br_addr, 32'h100);
        chk("beq_val", br_val, 32'd1);
        tick();
        chk("beq_req_drop", 32'(br_req), 32'd0);
        repeat (2) tick();
        chk("beq_empty_req", 32'(br_req), 32'd0);
        chk("beq_empty_ready", 32'(in_ready), 32'd1);

        // Signed / unsigned / undefined condition evaluation
        for (int i = 0; i < 6; i++) begin
            push(sg_op[i], 32'h140 + 32'(4 * i), 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1);
            expect_bcast($sformatf("sign%0d", i), 32'h140 + 32'(4 * i), sg_exp[i]);
        end

        // Ordering: an older waiting branch blocks a younger ready one
        push(OP_BNE, 32'h200, 32'hDEAD_BEEF, 4'd3, 1'b0, 32'd0, 4'd0, 1'b1);
        push(OP_BEQ, 32'h204, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 1'b1);
        seen = 0;
        repeat (5) begin
            tick();
            if (br_req) seen++;
        end
        chk("order_hold", 32'(seen), 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd3;
        cdb_data  = 32'd7;
        tick();
        cdb_valid = 1'b0;
        chk("wake_req_early", 32'(br_req), 32'd0);
        tick();
        chk("wake_req", 32'(br_req), 32'd1);
        chk("wake_addr", br_addr, 32'h200);
        chk("wake_val", br_val, 32'd1);
        tick();
        expect_bcast("order_b", 32'h204, 32'd1);

        // Full and pointer wrap
        br_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(OP_BEQ, 32'h300 + 32'(4 * i), 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1);
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        push(OP_BEQ, 32'h3F0, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1);
        chk("full_ready_9th", 32'(in_ready), 32'd0);
        chk("full_req", 32'(br_req), 32'd1);
        chk("full_addr", br_addr, 32'h300);
        br_grant = 1'b1;
        tick();
        br_grant = 1'b0;
        chk("unfull_ready", 32'(in_ready), 32'd1);
        popped    = 1;
        next_push = 8;
        n         = 0;
        br_grant  = 1'b1;
        while (popped < 16 && n < 300) begin
            if (br_req) begin
                chk($sformatf("wrap_pc%0d", popped), br_addr, 32'h300 + 32'(4 * popped));
                popped++;
            end
            set_entry(OP_BEQ, 32'h300 + 32'(4 * next_push), 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1);
            in_valid = (next_push < 16) && in_ready;
            tick();
            if (in_valid) next_push++;
            in_valid = 1'b0;
            n++;
        end
        chk("wrap_done", 32'(popped), 32'd16);
        repeat (3) tick();
        chk("wrap_empty_req", 32'(br_req), 32'd0);

        // Flush with a pending request and a same-cycle push
        br_grant = 1'b0;
        push(OP_BEQ, 32'h400, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1);
        tick();
        chk("flush_pre_req", 32'(br_req), 32'd1);
        set_entry(OP_BEQ, 32'h404, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1);
        flush_in = 1'b1;
        in_valid = 1'b1;
        tick();
        flush_in = 1'b0;
        in_valid = 1'b0;
        chk("flush_req", 32'(br_req), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        repeat (3) tick();
        chk("flush_empty_req", 32'(br_req), 32'd0);
        br_grant = 1'b1;
        push(OP_BEQ, 32'h408, 32'd2, 4'd0, 1'b1, 32'd3, 4'd0, 1'b1);
        expect_bcast("flush_after", 32'h408, 32'd0);

        // Pause: no pop and no wakeup while rdy_in is low
        br_grant = 1'b0;
        push(OP_BNE, 32'h500, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 1'b1);
        push(OP_BEQ, 32'h504, 32'd0, 4'd5, 1'b0, 32'd5, 4'd0, 1'b1);
        n = 0;
        while (!br_req && n < 10) begin
            tick();
            n++;
        end
        chk("pause_pre_req", 32'(br_req), 32'd1);
        rdy_in    = 1'b0;
        br_grant  = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("pause_req%0d", i), 32'(br_req), 32'd1);
            chk($sformatf("pause_addr%0d", i), br_addr, 32'h500);
            chk($sformatf("pause_val%0d", i), br_val, 32'd1);
            chk($sformatf("pause_ready%0d", i), 32'(in_ready), 32'd0);
            br_grant = ~br_grant;
        end
        rdy_in    = 1'b1;
        cdb_valid = 1'b0;
        br_grant  = 1'b1;
        chk("resume_req", 32'(br_req), 32'd1);
        tick();
        chk("resume_pop", 32'(br_req), 32'd0);
        seen = 0;
        repeat (4) begin
            tick();
            if (br_req) seen++;
        end
        chk("pause_no_wake", 32'(seen), 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'd5;
        tick();
        cdb_valid = 1'b0;
        expect_bcast("pause_wake", 32'h504, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

In-order branch resolution unit in the execute stage. It accepts decoded conditional branches from dispatch and captures their source operands from the common data bus. It evaluates each branch condition in program order and broadcasts the outcome on its CDB port as {address = branch PC, value[0] = taken}. This is the producer of the CDB results that the instruction-fetch branch predictor consumes in FIFO order to detect mispredictions and update its counters.

## Interface
Parameters:
- DEPTH_W, 3, log2 of entry count; depth = 2^DEPTH_W.
- TAG_W, 4, width of producer (ROB) tags.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global ready; low = pause (freeze all state)
- flush_in  in  1  misprediction flush (from predictor's predict_fail)
- in_valid  in  1  dispatch request
- in_ready  out  1  can accept: `!full && rdy_in`
- in_op  in  3  funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
- in_pc  in  32  branch PC
- in_rs1_val / in_rs2_val  in  32 each  operand value, valid when the matching rdy bit is set
- in_rs1_tag / in_rs2_tag  in  TAG_W each  producer tag, meaningful when not ready
- in_rs1_rdy / in_rs2_rdy  in  1 each  operand already available
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcasting producer tag
- cdb_data  in  32  broadcast value
- br_req  out  1  request CDB slot
- br_grant  in  1  CDB arbiter grant for this cycle
- br_addr  out  32  resolved branch PC
- br_val  out  32  {31'b0, taken}

## Operation
- Storage is a circular FIFO of 2^DEPTH_W entries. Each entry holds {op, pc, v1, t1, r1, v2, t2, r2}. There are front and rear pointers of DEPTH_W bits, which wrap naturally, plus a count of DEPTH_W+1 bits. full = (count == depth).
- Push: on in_valid && in_ready && !flush_in, write the entry at rear, rear+1, count+1.
- Push bypass: if a pushed operand is not ready and cdb_valid && cdb_tag == in tag in the same cycle, store it as ready with cdb_data.
- Wakeup: every valid entry with rX == 0 and tX == cdb_tag, while cdb_valid is high, sets vX = cdb_data and rX = 1. Both operands may wake in the same cycle.
- Condition evaluation:
  - EQ / NE compare all 32 bits.
  - LT / GE use signed 32-bit compare.
  - LTU / GEU use unsigned compare.
  - Undefined funct3 (010, 011) gives taken = 0.
- Head FSM:
  - IDLE: if count != 0 and head r1 && r2, register br_addr = head pc and br_val = {31'b0, taken}. Next state BCAST.
  - BCAST: br_req = 1, with br_addr and br_val held stable. On br_grant, pop the head (front+1, count-1) and go to IDLE.
- Branches are broadcast strictly in dispatch order. A younger ready branch never passes an older unready one.
- Push and pop in the same cycle leave count unchanged.
- flush_in (when rdy_in is high) has priority over everything:
  - count, front and rear go to 0; all entries are invalidated; FSM goes to IDLE.
  - Same-cycle push, wakeup and grant are discarded. A grant coinciding with a flush still counts as broadcast on the bus, but no state is kept.
- rdy_in low:
  - No state changes: no push, wakeup, pop or flush.
  - br_req, br_addr and br_val hold their values. br_grant is ignored.

## Timing
- Reset values: br_req 0, br_addr 0, br_val 0, count/front/rear 0, FSM IDLE. in_ready = rdy_in after reset.
- Latency when operands are ready at dispatch:
  - push at edge N;
  - head ready seen in IDLE during cycle N+1;
  - br_req high in cycle N+2.
- Latency from wakeup: a CDB wakeup of the head at edge M gives br_req high in cycle M+2.
- br_req stays high until a granted edge. It drops in the cycle after grant, so throughput is one branch per two cycles.
- in_ready is combinational from registered count and rdy_in. The cycle after a pop from full, it is high again.

## Test plan
- Basic BEQ: BEQ, pc 0x100, rs1 = rs2 = 5, both ready; br_grant tied to 1 -> br_req high 2 cycles after push, br_addr 0x100, br_val 1; then count 0.
- Signedness: BLT with rs1 0xFFFFFFFF, rs2 1 -> br_val 1. BLTU with the same operands -> br_val 0. BGEU with the same operands -> br_val 1.
- Ordering and wakeup:
  - Push A (BNE, pc 0x200, rs1 waiting on tag 3), then B (BEQ, pc 0x204, ready, equal operands).
  - No br_req while tag 3 is pending.
  - cdb tag 3 with data 7, rs2 = 0 -> broadcast 0x200 / val 1, then 0x204 / val 1.
- Full and wrap: with br_grant = 0, push 8 entries -> in_ready 0, and a 9th in_valid is ignored. Grant one -> in_ready 1. Push 8 more over time -> PCs broadcast in order across the pointer wrap.
- Flush: with br_req high and br_grant 0, assert flush_in one cycle -> next cycle br_req 0, count 0, in_ready 1. A push in the flush cycle is not stored.
- Pause: with br_req high, drop rdy_in for 3 cycles while pulsing br_grant and cdb_valid -> outputs are unchanged and nothing pops. After rdy_in rises, the grant pops normally.
